// File: rtl/task_4_pkg.sv
// Shared types and sizing helpers for the task 4 ingress buffer.
package task_4_pkg;

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_RECEIVE = 3'd1,
    s_DISCARD = 3'd2,
    s_FLUSH   = 3'd3,
    s_DRAIN   = 3'd4
  } task_input_enum;

  function automatic int cnt_width(input int num_words);
    return $clog2(num_words + 1);
  endfunction

  function automatic int fifo_addr_width(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/task_4_in_fifo.sv
// Synchronous first-word-fall-through FIFO; o_dout always shows the head entry.
module task_4_in_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_wr;
  logic                  w_rd;

  assign o_empty = (r_count == {(ADDR_WIDTH+1){1'b0}});
  assign o_full  = (r_count == (ADDR_WIDTH+1)'(DEPTH));
  assign w_wr    = i_wr_en && !o_full;
  assign w_rd    = i_rd_en && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr];

  // Storage array, left without reset so it can map onto RAM.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_wr_ptr <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr <= {ADDR_WIDTH{1'b0}};
      r_count  <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/task_4_in.sv
// Task 4 ingress buffer: stores a whole NUM_WORDS packet from the manager,
// then replays it to the core; wrong-length packets are dropped and flagged.
module task_4_in
  import task_4_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 81
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tmanager_data,
  input  logic                  i_tmanager_valid,
  input  logic                  i_tmanager_last,
  output logic                  o_ttask_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_core_ready,
  output logic                  o_input_last,
  output logic                  o_busy,
  output logic                  o_pkt_error
);

  localparam int             CW     = cnt_width(NUM_WORDS);
  localparam int             AW     = fifo_addr_width(NUM_WORDS);
  localparam logic [CW-1:0]  LP_N   = CW'(NUM_WORDS);
  localparam logic [CW-1:0]  LP_ONE = CW'(1);

  task_input_enum        r_state;
  task_input_enum        w_next;
  logic [CW-1:0]         r_cnt;
  logic                  w_accept;
  logic                  w_read;
  logic                  w_wr_en;
  logic                  w_fifo_wr;
  logic                  w_clear;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_cnt_hit;
  logic [DATA_WIDTH-1:0] w_dout;

  assign o_ttask_ready = (r_state == s_IDLE) || (r_state == s_RECEIVE) || (r_state == s_DISCARD);
  assign o_data_valid  = (r_state == s_DRAIN) && !w_empty;
  assign o_input_last  = o_data_valid && (r_cnt == LP_ONE);
  assign o_busy        = (r_state != s_IDLE);
  assign o_pkt_error   = (r_state == s_FLUSH);
  assign o_data        = o_data_valid ? w_dout : {DATA_WIDTH{1'b0}};

  assign w_accept  = i_tmanager_valid && o_ttask_ready;
  assign w_read    = o_data_valid && i_core_ready;
  assign w_cnt_hit = ((r_cnt + LP_ONE) == LP_N);
  assign w_fifo_wr = w_wr_en && !w_full;
  // Reset also empties the FIFO so no stale words survive a mid-packet reset.
  assign w_clear   = i_rst || (r_state == s_FLUSH);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= s_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_wr_en = 1'b0;
    case (r_state)
      s_IDLE: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (NUM_WORDS == 1) begin
            w_next = i_tmanager_last ? s_DRAIN : s_DISCARD;
          end else begin
            w_next = i_tmanager_last ? s_FLUSH : s_RECEIVE;
          end
        end else begin
          w_next = s_IDLE;
        end
      end
      s_RECEIVE: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (i_tmanager_last) begin
            w_next = w_cnt_hit ? s_DRAIN : s_FLUSH;
          end else if (w_cnt_hit) begin
            w_next = s_DISCARD;
          end else begin
            w_next = s_RECEIVE;
          end
        end else begin
          w_next = s_RECEIVE;
        end
      end
      s_DISCARD: begin
        if (w_accept && i_tmanager_last) begin
          w_next = s_FLUSH;
        end else begin
          w_next = s_DISCARD;
        end
      end
      s_FLUSH: w_next = s_IDLE;
      s_DRAIN: begin
        if (w_read && (r_cnt == LP_ONE)) begin
          w_next = s_IDLE;
        end else begin
          w_next = s_DRAIN;
        end
      end
      default: w_next = s_IDLE;
    endcase
  end

  // r_cnt tracks words held in the FIFO; discarded words are not counted.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state == s_FLUSH)) begin
      r_cnt <= {CW{1'b0}};
    end else if (w_wr_en) begin
      r_cnt <= (r_state == s_IDLE) ? LP_ONE : (r_cnt + LP_ONE);
    end else if (w_read) begin
      r_cnt <= r_cnt - LP_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  task_4_in_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_clear (w_clear),
    .i_wr_en (w_fifo_wr),
    .i_din   (i_tmanager_data),
    .i_rd_en (w_read),
    .o_dout  (w_dout),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

endmodule

// File: tb/tb_task_4_in.sv
// Scoreboard bench for task_4_in: packets are modelled as whole queues of
// words; good packets feed the expected-output queue, bad ones an error count.
module tb_task_4_in;

  localparam int DW = 8;
  localparam int NW = 81;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_tmanager_data;
  logic          i_tmanager_valid;
  logic          i_tmanager_last;
  logic          o_ttask_ready;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          i_core_ready;
  logic          o_input_last;
  logic          o_busy;
  logic          o_pkt_error;

  int   vectors     = 0;
  int   miscompares = 0;
  int   err_exp     = 0;
  int   err_seen    = 0;
  int   rd_cnt      = 0;
  int   rdy_mode    = 0;
  exp_t exp_q[$];

  logic          stall_r = 1'b0;
  logic [DW-1:0] stall_data;

  task_4_in #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_tmanager_data  (i_tmanager_data),
    .i_tmanager_valid (i_tmanager_valid),
    .i_tmanager_last  (i_tmanager_last),
    .o_ttask_ready    (o_ttask_ready),
    .o_data           (o_data),
    .o_data_valid     (o_data_valid),
    .i_core_ready     (i_core_ready),
    .o_input_last     (o_input_last),
    .o_busy           (o_busy),
    .o_pkt_error      (o_pkt_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Core-side ready pattern, selected by rdy_mode.
  initial begin
    i_core_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        1:       i_core_ready = ~i_core_ready;
        2:       i_core_ready = 1'($urandom_range(0, 1));
        default: i_core_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every core read.
  always @(negedge i_clk) begin
    if (i_rst) begin
      exp_q.delete();
      stall_r = 1'b0;
    end else begin
      if (stall_r) begin
        check("stall_hold_valid", int'(o_data_valid), 1);
        check("stall_hold_data", int'(o_data), int'(stall_data));
      end
      if (o_data_valid) begin
        check("ready_low_in_drain", int'(o_ttask_ready), 0);
      end else if (o_input_last) begin
        check("last_without_valid", int'(o_input_last), 0);
      end
      if (o_data_valid && i_core_ready) begin
        rd_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_core_word", int'(o_data), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("core_data", int'(o_data), int'(e.data));
          check("core_last", int'(o_input_last), int'(e.last));
        end
      end
      if (o_pkt_error) err_seen++;
      stall_r    = o_data_valid && !i_core_ready;
      stall_data = o_data;
    end
  end

  // Sends one packet; gap: 0 none, 2 gives 1-in-3 duty, 3 random idles.
  task automatic send_pkt(input int len, input int gap, input bit seq);
    logic [DW-1:0] words[$];
    for (int i = 0; i < len; i++) words.push_back(seq ? DW'(i) : DW'($urandom));
    if (len == NW) begin
      for (int i = 0; i < len; i++) exp_q.push_back('{data: words[i], last: (i == len - 1)});
    end else begin
      err_exp++;
    end
    for (int i = 0; i < len; i++) begin
      int  idle;
      bit  acc;
      bit  rdy;
      int  guard;
      idle = (gap == 3) ? int'($urandom_range(0, 1)) : gap;
      repeat (idle) begin
        @(posedge i_clk);
        #1;
      end
      i_tmanager_valid = 1'b1;
      i_tmanager_data  = words[i];
      i_tmanager_last  = (i == len - 1);
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 5000) begin
        @(negedge i_clk);
        rdy = o_ttask_ready;
        @(posedge i_clk);
        #1;
        acc = rdy;
        guard++;
      end
      i_tmanager_valid = 1'b0;
      i_tmanager_last  = 1'b0;
      if (!acc) begin
        check("accept_timeout", 0, 1);
        return;
      end
    end
    @(negedge i_clk);
    if (len == NW) begin
      check("valid_after_last_accept", int'(o_data_valid), 1);
    end else begin
      check("error_after_bad_pkt", int'(o_pkt_error), 1);
      check("no_valid_on_bad_pkt", int'(o_data_valid), 0);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || o_busy) && guard < 5000) begin
      @(posedge i_clk);
      #1;
      guard++;
    end
    if (guard >= 5000) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int base;
    int guard;
    i_rst            = 1'b1;
    i_tmanager_data  = '0;
    i_tmanager_valid = 1'b0;
    i_tmanager_last  = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_ttask_ready", int'(o_ttask_ready), 1);
    check("rst_data_valid", int'(o_data_valid), 0);
    check("rst_input_last", int'(o_input_last), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_pkt_error", int'(o_pkt_error), 0);
    check("rst_data", int'(o_data), 0);
    @(posedge i_clk);
    #1;

    rdy_mode = 0; send_pkt(NW, 0, 1'b1);
    rdy_mode = 1; send_pkt(NW, 0, 1'b1);
    rdy_mode = 2; send_pkt(40, 0, 1'b0);
    send_pkt(NW, 0, 1'b0);
    send_pkt(100, 0, 1'b0);
    wait_idle();
    check("long_pkt_idle_after", int'(o_busy), 0);

    // Reset in the middle of draining a packet.
    rdy_mode = 0;
    base = rd_cnt;
    send_pkt(NW, 0, 1'b0);
    guard = 0;
    while (rd_cnt < base + 30 && guard < 1000) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 1000) check("mid_drain_timeout", 0, 1);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_rst_data_valid", int'(o_data_valid), 0);
    check("post_rst_busy", int'(o_busy), 0);
    check("post_rst_ttask_ready", int'(o_ttask_ready), 1);
    check("post_rst_no_error", int'(o_pkt_error), 0);
    @(posedge i_clk);
    #1;
    send_pkt(NW, 0, 1'b0);

    rdy_mode = 0; send_pkt(NW, 2, 1'b1);

    for (int p = 0; p < 6; p++) begin
      int sel;
      int len;
      sel = int'($urandom_range(0, 2));
      len = (sel == 0) ? NW : (sel == 1) ? int'($urandom_range(1, NW - 1)) : int'($urandom_range(NW + 1, 130));
      rdy_mode = int'($urandom_range(0, 2));
      send_pkt(len, 3, 1'b0);
    end

    wait_idle();
    check("error_pulse_count", err_seen, err_exp);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
